// File: rtl/dmem_axi_bridge_pkg.sv
// Shared encodings for the CPU-side AXI bridges: FSM states, AXI burst/size codes, fixed IDs.
package dmem_axi_bridge_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RD_AR  = 3'd1;
  localparam logic [2:0] ST_RD_R   = 3'd2;
  localparam logic [2:0] ST_WR_AWW = 3'd3;
  localparam logic [2:0] ST_WR_B   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    RD_AR  = ST_RD_AR,
    RD_R   = ST_RD_R,
    WR_AWW = ST_WR_AWW,
    WR_B   = ST_WR_B,
    DONE   = ST_DONE
  } dmemState_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_B     = 3'd0;
  localparam logic [2:0] SIZE_H     = 3'd1;
  localparam logic [2:0] SIZE_W     = 3'd2;

  localparam logic [3:0] IFETCH_AXI_ID = 4'd0;
  localparam logic [3:0] DMEM_AXI_ID   = 4'd1;

endpackage

// File: rtl/dmem_axi_bridge_axi_size_enc.sv
// Byte-select to AXI transfer size; unusual patterns fall back to a full word.
module axi_size_enc
  import dmem_axi_bridge_pkg::*;
(
  input  logic [3:0] sel,
  output logic [2:0] size
);

  always_comb begin
    size = SIZE_W;
    case (sel)
      4'b1111:                         size = SIZE_W;
      4'b0011, 4'b1100:                size = SIZE_H;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_B;
      default:                         size = SIZE_W;
    endcase
  end

endmodule

// File: rtl/dmem_axi_bridge.sv
// M-stage data-memory port to single-beat AXI3 master; one transaction in flight, stalls the CPU meanwhile.
module dmem_axi_bridge
  import dmem_axi_bridge_pkg::*;
#(
  parameter logic [3:0] AXI_ID = DMEM_AXI_ID,
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic              mem_wr,
  input  logic [3:0]        mem_sel,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              stall_other,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              d_stall,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [3:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid,
  output logic              rready,
  output logic [3:0]        awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [3:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic              bvalid,
  output logic              bready
);

  dmemState_t        state, stateNext;
  logic [ADDR_W-1:0] addrQ;
  logic [2:0]        sizeQ, sizeIn;
  logic [3:0]        selQ;
  logic [DATA_W-1:0] wdataQ;
  logic              awOk, wOk;
  logic              awDone, wDone;

  axi_size_enc uSizeEnc (.sel(mem_sel), .size(sizeIn));

  assign arid    = AXI_ID;
  assign awid    = AXI_ID;
  assign arlen   = 4'd0;
  assign awlen   = 4'd0;
  assign arburst = BURST_INCR;
  assign awburst = BURST_INCR;
  assign wlast   = 1'b1;
  assign araddr  = addrQ;
  assign awaddr  = addrQ;
  assign arsize  = sizeQ;
  assign awsize  = sizeQ;
  assign wdata   = wdataQ;
  assign wstrb   = selQ;

  // A channel counts as done if it handshook earlier or is handshaking now.
  assign awDone = awOk | (awvalid & awready);
  assign wDone  = wOk  | (wvalid & wready);

  always_comb begin
    stateNext = state;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    d_stall   = 1'b1;
    case (state)
      IDLE: begin
        d_stall = mem_en;
        if (mem_en) stateNext = mem_wr ? WR_AWW : RD_AR;
      end
      RD_AR: begin
        arvalid = 1'b1;
        if (arready) stateNext = RD_R;
      end
      RD_R: begin
        rready = 1'b1;
        if (rvalid) stateNext = DONE;
      end
      WR_AWW: begin
        awvalid = ~awOk;
        wvalid  = ~wOk;
        if (awDone && wDone) stateNext = WR_B;
      end
      WR_B: begin
        bready = 1'b1;
        if (bvalid) stateNext = DONE;
      end
      DONE: begin
        // mem_en still reflects the finished instruction; wait for the pipeline to move.
        d_stall = 1'b0;
        if (!stall_other) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_rdata <= '0;
      awOk      <= 1'b0;
      wOk       <= 1'b0;
      addrQ     <= '0;
      sizeQ     <= SIZE_W;
      selQ      <= '0;
      wdataQ    <= '0;
    end else begin
      state <= stateNext;
      if (state == IDLE && mem_en) begin
        addrQ  <= mem_addr;
        sizeQ  <= sizeIn;
        selQ   <= mem_sel;
        wdataQ <= mem_wdata;
      end
      if (state == RD_R && rvalid) mem_rdata <= rdata;
      if (state == WR_AWW) begin
        awOk <= (awDone && wDone) ? 1'b0 : awDone;
        wOk  <= (awDone && wDone) ? 1'b0 : wDone;
      end
    end
  end

endmodule

// File: tb/tb_dmem_axi_bridge.sv
// Directed bench: load, delayed-AW store, DONE hold, store->load, mid-read reset, idle bus.
module tb_dmem_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en, mem_wr, stall_other;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        d_stall;
  logic [3:0]  arid, arlen, awid, awlen, wstrb;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_axi_bridge #(.AXI_ID(4'd1), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wr(mem_wr), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .stall_other(stall_other),
    .mem_rdata(mem_rdata), .d_stall(d_stall),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready), .bvalid(bvalid), .bready(bready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are then changed at +1 and outputs sampled at +2.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic noBus(input string tag);
    chk({tag, "_arvalid"}, {31'd0, arvalid}, 32'd0);
    chk({tag, "_awvalid"}, {31'd0, awvalid}, 32'd0);
    chk({tag, "_wvalid"},  {31'd0, wvalid},  32'd0);
  endtask

  initial begin
    rst = 1'b1; mem_en = 1'b0; mem_wr = 1'b0; stall_other = 1'b0;
    mem_sel = 4'h0; mem_addr = '0; mem_wdata = '0;
    arready = 1'b0; rdata = '0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    settle();
    chk("rst_dstall", {31'd0, d_stall}, 32'd0);
    noBus("rst");
    chk("rst_rready", {31'd0, rready}, 32'd0);
    chk("rst_bready", {31'd0, bready}, 32'd0);
    chk("rst_rdata", mem_rdata, 32'h0);
    chk("tie_arlen", {28'd0, arlen}, 32'd0);
    chk("tie_awlen", {28'd0, awlen}, 32'd0);
    chk("tie_arburst", {30'd0, arburst}, 32'd1);
    chk("tie_awburst", {30'd0, awburst}, 32'd1);
    chk("tie_wlast", {31'd0, wlast}, 32'd1);
    chk("tie_arid", {28'd0, arid}, 32'd1);
    chk("tie_awid", {28'd0, awid}, 32'd1);

    // Load, zero-wait slave
    tick();
    mem_en = 1'b1; mem_wr = 1'b0; mem_addr = 32'h8000_0010; mem_sel = 4'hF;
    settle();
    chk("ld_c1_dstall", {31'd0, d_stall}, 32'd1);
    chk("ld_c1_arvalid", {31'd0, arvalid}, 32'd0);
    tick();
    mem_addr = 32'h1234_5678; mem_sel = 4'h1;
    arready = 1'b1;
    settle();
    chk("ld_c2_arvalid", {31'd0, arvalid}, 32'd1);
    chk("ld_c2_araddr", araddr, 32'h8000_0010);
    chk("ld_c2_arsize", {29'd0, arsize}, 32'd2);
    chk("ld_c2_dstall", {31'd0, d_stall}, 32'd1);
    tick();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    settle();
    chk("ld_c3_arvalid", {31'd0, arvalid}, 32'd0);
    chk("ld_c3_rready", {31'd0, rready}, 32'd1);
    chk("ld_c3_dstall", {31'd0, d_stall}, 32'd1);
    tick();
    rvalid = 1'b0; rdata = 32'h0; stall_other = 1'b1;
    settle();
    chk("ld_c4_dstall", {31'd0, d_stall}, 32'd0);
    chk("ld_c4_rdata", mem_rdata, 32'hDEAD_BEEF);
    chk("ld_c4_rready", {31'd0, rready}, 32'd0);

    // Held in DONE by an external stall
    for (int i = 0; i < 5; i++) begin
      if (i == 4) stall_other = 1'b0;
      tick();
      settle();
      if (i < 4) begin
        chk("hold_dstall", {31'd0, d_stall}, 32'd0);
        chk("hold_rdata", mem_rdata, 32'hDEAD_BEEF);
        chk("hold_arvalid", {31'd0, arvalid}, 32'd0);
      end
    end
    // First edge with stall_other=0 left DONE: IDLE with mem_en=1 stalls again
    chk("hold_exit_idle", {31'd0, d_stall}, 32'd1);
    mem_en = 1'b0;
    settle();
    chk("idle_noreq_dstall", {31'd0, d_stall}, 32'd0);
    noBus("idle_noreq");

    // Byte store with AW accepted in its 3rd cycle, W immediately
    tick();
    mem_en = 1'b1; mem_wr = 1'b1; mem_addr = 32'h8000_0023; mem_sel = 4'b1000;
    mem_wdata = 32'hAB00_0000; wready = 1'b1;
    settle();
    chk("st_c1_dstall", {31'd0, d_stall}, 32'd1);
    tick();
    mem_addr = 32'h0; mem_sel = 4'hF; mem_wdata = 32'h0;
    settle();
    chk("st_awvalid1", {31'd0, awvalid}, 32'd1);
    chk("st_wvalid1", {31'd0, wvalid}, 32'd1);
    chk("st_awaddr", awaddr, 32'h8000_0023);
    chk("st_awsize", {29'd0, awsize}, 32'd0);
    chk("st_wstrb", {28'd0, wstrb}, 32'h8);
    chk("st_wdata", wdata, 32'hAB00_0000);
    tick();
    wready = 1'b0;
    settle();
    chk("st_wvalid2", {31'd0, wvalid}, 32'd0);
    chk("st_awvalid2", {31'd0, awvalid}, 32'd1);
    chk("st_dstall2", {31'd0, d_stall}, 32'd1);
    tick();
    awready = 1'b1;
    settle();
    chk("st_awvalid3", {31'd0, awvalid}, 32'd1);
    chk("st_wvalid3", {31'd0, wvalid}, 32'd0);
    tick();
    awready = 1'b0;
    settle();
    chk("st_b_awvalid", {31'd0, awvalid}, 32'd0);
    chk("st_b_bready", {31'd0, bready}, 32'd1);
    chk("st_b_dstall", {31'd0, d_stall}, 32'd1);
    tick();
    settle();
    chk("st_bwait_dstall", {31'd0, d_stall}, 32'd1);
    bvalid = 1'b1;
    settle();
    chk("st_bvalid_dstall", {31'd0, d_stall}, 32'd1);
    tick();
    bvalid = 1'b0;
    // Next instruction (a load) is presented as the store completes
    mem_wr = 1'b0; mem_addr = 32'h8000_0100; mem_sel = 4'b0011;
    settle();
    chk("st_done_dstall", {31'd0, d_stall}, 32'd0);
    chk("st_done_bready", {31'd0, bready}, 32'd0);
    chk("s2l_done_arvalid", {31'd0, arvalid}, 32'd0);
    tick();
    settle();
    chk("s2l_idle_arvalid", {31'd0, arvalid}, 32'd0);
    chk("s2l_idle_dstall", {31'd0, d_stall}, 32'd1);
    tick();
    arready = 1'b1;
    settle();
    chk("s2l_arvalid", {31'd0, arvalid}, 32'd1);
    chk("s2l_awvalid", {31'd0, awvalid}, 32'd0);
    chk("s2l_araddr", araddr, 32'h8000_0100);
    chk("s2l_arsize", {29'd0, arsize}, 32'd1);
    tick();
    arready = 1'b0;
    settle();
    chk("rr_rready", {31'd0, rready}, 32'd1);

    // Reset while waiting for R
    rst = 1'b1; mem_en = 1'b0;
    tick();
    rst = 1'b0;
    settle();
    chk("rstmid_rready", {31'd0, rready}, 32'd0);
    chk("rstmid_rdata", mem_rdata, 32'h0);
    chk("rstmid_dstall", {31'd0, d_stall}, 32'd0);
    noBus("rstmid");

    // Irregular byte select falls back to word size
    tick();
    mem_en = 1'b1; mem_wr = 1'b0; mem_addr = 32'h8000_0040; mem_sel = 4'b0110;
    tick();
    mem_en = 1'b0; arready = 1'b1;
    settle();
    chk("odd_arsize", {29'd0, arsize}, 32'd2);
    tick();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h0BAD_F00D;
    tick();
    rvalid = 1'b0;
    settle();
    chk("odd_rdata", mem_rdata, 32'h0BAD_F00D);
    chk("odd_done_dstall", {31'd0, d_stall}, 32'd0);

    // Quiet bus while mem_en stays low
    for (int i = 0; i < 10; i++) begin
      tick();
      settle();
      chk("quiet_dstall", {31'd0, d_stall}, 32'd0);
      noBus("quiet");
      chk("quiet_rready", {31'd0, rready}, 32'd0);
      chk("quiet_bready", {31'd0, bready}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_axi_bridge.md
Name: dmem_axi_bridge

Overview:
- Memory-side responder for the CPU data-memory port (M stage: mem_en, byte-select, address, write data).
- Returns read data and drives d_stall.
- Acts as a single-beat AXI3 master toward the system interconnect: one outstanding transaction, no cache, no burst.
- Sits between the datapath's M stage and the AXI crossbar, alongside the existing instruction-fetch bridge.

Parameters:
- AXI_ID, 4'd1: constant ID driven on arid and awid.
- ADDR_W, 32: address width.
- DATA_W, 32: data width. Only 32 is supported.

Ports:
- clk  in  1  Single clock.
- rst  in  1  Synchronous, active-high reset.
- mem_en  in  1  Request valid. Already gated by the CPU for exceptions and misalignment.
- mem_wr  in  1  1 = store, 0 = load.
- mem_sel  in  4  Byte enables for stores and byte lanes for loads.
- mem_addr  in  32  Byte address.
- mem_wdata  in  32  Store data, already lane-shifted.
- stall_other  in  1  CPU pipeline stall from any source other than this block.
- mem_rdata  out  32  Load data, valid while d_stall=0 after a load.
- d_stall  out  1  Holds the M stage.
- arid, araddr, arlen, arsize, arburst, arvalid  out  4/32/4/3/2/1  AXI read address channel.
- arready  in  1
- rdata  in  32
- rvalid  in  1
- rready  out  1
- awid, awaddr, awlen, awsize, awburst, awvalid  out  4/32/4/3/2/1  AXI write address channel.
- awready  in  1
- wdata, wstrb, wlast, wvalid  out  32/4/1/1  AXI write data channel.
- wready  in  1
- bvalid  in  1
- bready  out  1

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE.
  - arvalid, awvalid, wvalid, rready, bready all 0.
  - mem_rdata=0, internal aw_ok/w_ok flags cleared.
  - d_stall follows its combinational rule, so d_stall=0 while mem_en=0.
- Tied outputs: arlen=awlen=0, arburst=awburst=2'b01, wlast=1, arid=awid=AXI_ID.
- Size encoding from mem_sel:
  - 4'b1111 -> 3'd2
  - 4'b0011 or 4'b1100 -> 3'd1
  - one-hot -> 3'd0
  - any other value -> 3'd2
- States: IDLE, RD_AR, RD_R, WR_AWW, WR_B, DONE.
- IDLE:
  - If mem_en=1, the request is captured into registers (addr, size, sel, wdata) at the clock edge.
  - Next state is RD_AR when mem_wr=0, else WR_AWW.
- d_stall (combinational):
  - 1 when state is IDLE and mem_en=1.
  - 1 in RD_AR, RD_R, WR_AWW and WR_B.
  - 0 in DONE, and 0 in IDLE when mem_en=0.
- RD_AR: arvalid=1 with the registered address and size. On arready -> RD_R, arvalid drops the same edge.
- RD_R: rready=1. On rvalid, capture rdata into mem_rdata -> DONE.
- WR_AWW:
  - awvalid and wvalid both asserted; wstrb=registered sel.
  - Each valid drops independently after its own handshake, tracked by aw_ok and w_ok.
  - Same-cycle handshakes on both channels are allowed.
  - When both have completed -> WR_B.
- WR_B: bready=1. On bvalid -> DONE.
- DONE:
  - d_stall=0; mem_rdata held stable.
  - No new request is issued while in DONE, even though mem_en is still high for the same instruction.
  - When stall_other=0 -> IDLE. The pipeline advances on that edge.
  - While stall_other=1, stay in DONE indefinitely.
- Latency, zero-wait slave:
  - Load: request cycle, AR, R -> d_stall low on the 4th cycle.
  - Store: request, AW+W, B -> d_stall low on the 4th cycle.
- AXI valids are never withdrawn before their handshake. Request inputs are ignored outside IDLE because the registered copy is used.
- Reset mid-transaction returns the block to IDLE immediately. The interconnect shares the same rst, so no orphaned transaction needs to be handled.
- A read is never issued speculatively; mem_en=0 in IDLE produces no bus activity.

Decomposition:
- Shared package:
  - state encoding (3-bit localparams);
  - AXI constants: BURST_INCR=2'b01, SIZE_B/H/W;
  - the fixed ID values for the instruction and data bridges.
- One natural sub-module: axi_size_enc, combinational sel[3:0] -> size[2:0].

Test Plan:
- Load, zero-wait slave: mem_en=1, mem_wr=0, addr=0x8000_0010, sel=4'hF; slave returns 0xDEADBEEF.
  -> araddr=0x8000_0010, arsize=2; d_stall high for 3 cycles; mem_rdata=0xDEADBEEF with d_stall=0 on cycle 4.
- Byte store: addr=0x8000_0023, sel=4'b1000, wdata=0xAB00_0000.
  -> awsize=0, wstrb=4'b1000, wdata=0xAB00_0000.
  - Slave awready delayed 3 cycles, wready immediate: wvalid drops after 1 cycle, awvalid held until accepted.
  - d_stall falls only after the bvalid cycle.
- stall_other=1 for 5 cycles after load completion.
  -> stays in DONE with d_stall=0; mem_rdata stable; no second arvalid is issued.
  - Returns to IDLE on the first cycle with stall_other=0.
- Back-to-back store then load.
  -> the load's arvalid appears only after the store's bvalid and the DONE cycle; exactly one outstanding transaction at a time.
- rst asserted while in RD_R with arvalid already accepted.
  -> next edge: state=IDLE, rready=0, mem_rdata=0; d_stall=0 while mem_en=0.
- mem_en=0 for 10 cycles.
  -> no valid ever asserted; d_stall=0 throughout.
